// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM encoding and default widths.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int ADDR_W_DEF = 9;
   localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on request, holding at the all-ones ceiling instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed data memory target with programmable wait states, range
// checking, saturating access counters and a combinational debug read port.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DEPTH       = 512,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count
);

   // Index width covers only the implemented words; addresses are range
   // checked against DEPTH before the low bits are used as an index.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WC_W  = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   logic [31:0]       mem [DEPTH];

   state_t            state;
   state_t            next_state;
   logic [WC_W-1:0]   wcnt;

   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;

   logic              cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [IDX_W-1:0]  cur_idx;
   logic              in_range;
   logic              commit;
   logic              accept;
   logic              rd_inc;
   logic              wr_inc;
   logic              dbg_in_range;

   // With zero wait states the commit happens on the accepting edge, before
   // the latches are loaded, so the live request fields are used in IDLE.
   assign cur_we       = (state == S_IDLE) ? req_we    : lat_we;
   assign cur_addr     = (state == S_IDLE) ? req_addr  : lat_addr;
   assign cur_wdata    = (state == S_IDLE) ? req_wdata : lat_wdata;
   assign cur_idx      = cur_addr[IDX_W-1:0];
   assign in_range     = (32'(cur_addr) < DEPTH);
   assign accept       = (state == S_IDLE) && req_valid;

   assign rd_inc       = commit && in_range && !cur_we;
   assign wr_inc       = commit && in_range && cur_we;

   assign dbg_in_range = (32'(dbg_addr) < DEPTH);
   assign dbg_data     = dbg_in_range ? mem[dbg_addr[IDX_W-1:0]] : 32'd0;

   // Next-state and handshake decode; commit marks the edge entering RESP.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (wcnt == WC_W'(1)) begin
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
      commit = (next_state == S_RESP) && (state != S_RESP);
   end

   // State, wait counter and response registers; reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wcnt       <= '0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            wcnt <= WC_W'(WAIT_CYCLES);
         end else if (state == S_WAIT) begin
            wcnt <= wcnt - 1'b1;
         end
         if (commit) begin
            resp_rdata <= (in_range && !cur_we) ? mem[cur_idx] : 32'd0;
            resp_err   <= !in_range;
         end
      end
   end

   // Capture the request on acceptance; later changes on the bus are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

   // Memory array write; not cleared by reset, and a reset on the commit edge blocks it.
   always_ff @(posedge clk) begin
      if (!rst && wr_inc) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_inc),
      .count (rd_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wr_inc),
      .count (wr_count)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: unit A (2 wait states, 256 words,
// 4-bit counters) and unit B (0 wait states, default sizes).
module tb_mem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        a_req_valid = 1'b0, a_req_we = 1'b0;
   logic [8:0]  a_req_addr = '0, a_dbg_addr = '0;
   logic [31:0] a_req_wdata = '0;
   logic        a_req_ready, a_resp_valid, a_resp_err;
   logic [31:0] a_resp_rdata, a_dbg_data;
   logic [3:0]  a_rd_count, a_wr_count;

   logic        b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [8:0]  b_req_addr = '0, b_dbg_addr = '0;
   logic [31:0] b_req_wdata = '0;
   logic        b_req_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_resp_rdata, b_dbg_data;
   logic [15:0] b_rd_count, b_wr_count;

   resp_t q_a[$];
   resp_t q_b[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
      .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data),
      .rd_count(a_rd_count), .wr_count(a_wr_count)
   );

   mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
      .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data),
      .rd_count(b_rd_count), .wr_count(b_wr_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor A: every response must match the oldest expected entry.
   always @(negedge clk) begin
      if (a_resp_valid) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_resp", 32'd1, 32'd0);
         end else begin
            resp_t e;
            e = q_a.pop_front();
            chk("a_rdata", a_resp_rdata, e.rdata);
            chk("a_err", {31'd0, a_resp_err}, {31'd0, e.err});
         end
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (b_resp_valid) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_resp", 32'd1, 32'd0);
         end else begin
            resp_t e;
            e = q_b.pop_front();
            chk("b_rdata", b_resp_rdata, e.rdata);
            chk("b_err", {31'd0, b_resp_err}, {31'd0, e.err});
         end
      end
   end

   // Issue one request to unit sel (0=A, 1=B) and check handshake timing.
   // Entered #1 after edge T; the request is accepted at edge T+1 and the
   // response must be visible after edge T+1+WAIT_CYCLES.
   task automatic txn(input int sel, input logic we, input logic [8:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
      int    n;
      int    w;
      resp_t e;
      w = (sel == 0) ? 2 : 0;
      e.rdata = exp_rd;
      e.err   = exp_err;
      if (sel == 0) begin
         chk("a_ready_idle", {31'd0, a_req_ready}, 32'd1);
         q_a.push_back(e);
         a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
      end else begin
         chk("b_ready_idle", {31'd0, b_req_ready}, 32'd1);
         q_b.push_back(e);
         b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      a_req_wdata = 32'hFFFF_FFFF;
      n = 1;
      while (((sel == 0) ? a_resp_valid : b_resp_valid) == 1'b0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk((sel == 0) ? "a_latency" : "b_latency", n, w + 1);
      chk((sel == 0) ? "a_ready_in_resp" : "b_ready_in_resp",
          {31'd0, (sel == 0) ? a_req_ready : b_req_ready}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", {31'd0, a_req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      chk("rst_rd_count", {28'd0, a_rd_count}, 32'd0);
      chk("rst_wr_count", {28'd0, a_wr_count}, 32'd0);
      chk("rst_rdata", a_resp_rdata, 32'd0);

      // Store then load with two wait states.
      txn(0, 1'b1, 9'd5, 32'hDEADBEEF, 32'd0, 1'b0);
      txn(0, 1'b0, 9'd5, 32'd0, 32'hDEADBEEF, 1'b0);
      chk("a_wr_count_1", {28'd0, a_wr_count}, 32'd1);
      chk("a_rd_count_1", {28'd0, a_rd_count}, 32'd1);
      a_dbg_addr = 9'd5; #1;
      chk("a_dbg_5", a_dbg_data, 32'hDEADBEEF);

      // Out-of-range store and load: error, zero data, counters unchanged.
      txn(0, 1'b1, 9'd300, 32'h1111_2222, 32'd0, 1'b1);
      chk("a_wr_count_oor", {28'd0, a_wr_count}, 32'd1);
      txn(0, 1'b0, 9'd300, 32'd0, 32'd0, 1'b1);
      chk("a_rd_count_oor", {28'd0, a_rd_count}, 32'd1);
      a_dbg_addr = 9'd300; #1;
      chk("a_dbg_oor", a_dbg_data, 32'd0);

      // Seed address 7, then abandon a store to it with a reset in WAIT.
      txn(0, 1'b1, 9'd7, 32'h0000_AAAA, 32'd0, 1'b0);
      chk("a_wr_count_2", {28'd0, a_wr_count}, 32'd2);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'd7; a_req_wdata = 32'h0000_1234;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         if (a_resp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("a_abort_no_resp", seen, 0);
      a_dbg_addr = 9'd7; #1;
      chk("a_abort_mem7", a_dbg_data, 32'h0000_AAAA);
      chk("a_abort_rd_count", {28'd0, a_rd_count}, 32'd0);
      chk("a_abort_wr_count", {28'd0, a_wr_count}, 32'd0);
      chk("a_abort_idle", {31'd0, a_req_ready}, 32'd1);

      // Saturation: 17 loads, counter climbs to 15 and holds.
      for (int i = 1; i <= 17; i++) begin
         txn(0, 1'b0, 9'd7, 32'd0, 32'h0000_AAAA, 1'b0);
         chk("a_rd_sat", {28'd0, a_rd_count}, (i > 15) ? 32'd15 : 32'(i));
      end

      // Zero wait states on unit B.
      txn(1, 1'b1, 9'd0, 32'h0000_0005, 32'd0, 1'b0);
      txn(1, 1'b0, 9'd0, 32'd0, 32'h0000_0005, 1'b0);
      chk("b_rd_count", {16'd0, b_rd_count}, 32'd1);
      chk("b_wr_count", {16'd0, b_wr_count}, 32'd1);
      chk("b_ready_after", {31'd0, b_req_ready}, 32'd1);

      repeat (3) @(posedge clk);
      chk("a_queue_empty", q_a.size(), 0);
      chk("b_queue_empty", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data-memory target that services load/store requests from the multi-cycle CPU over a valid/ready request and one-cycle response handshake.
- Inserts a programmable number of wait states per access, so the CPU's memory states are tested against non-zero latency.
- Flags out-of-range addresses and keeps saturating read/write access counters.
- Provides an asynchronous debug read port that feeds the seven-segment display mux.

Parameters:
- ADDR_W, 9, width of the word address.
- DEPTH, 512, number of 32-bit words implemented; valid addresses are 0..DEPTH-1 (DEPTH <= 2**ADDR_W).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; 0 is legal.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  initiator has a request; held stable until accepted.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle pulse; response fields are valid.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  address was out of range; qualified by resp_valid.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  32  combinational read of mem[dbg_addr]; 0 if out of range.
- rd_count  out  CNT_W  successful loads, saturating.
- wr_count  out  CNT_W  successful stores, saturating.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, rd_count=0, wr_count=0, wait counter=0.
  - Memory array contents are NOT cleared.
  - Reset has priority over every other action in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1, latch we/addr/wdata and load wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter reaches 1, next state is RESP.
- Transition into RESP (same edge):
  - Range check on the latched address.
  - In range, store: mem[addr] <= wdata; wr_count++.
  - In range, load: resp_rdata <= mem[addr]; rd_count++.
  - Out of range: no write, resp_rdata <= 0, resp_err <= 1, neither counter changes.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; next state is IDLE.
  - resp_rdata and resp_err hold until the next response.
- Latency: request accepted at edge T gives resp_valid high in the cycle after edge T+1+WAIT_CYCLES. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Back-to-back: if req_valid is still high in the IDLE cycle after RESP, it is treated as a new request (the initiator deasserts during RESP to avoid this).
- Counters saturate at all-ones; no wrap.
- Debug port:
  - Asynchronous read, independent of the FSM.
  - During the edge that commits a store to the same address, dbg_data shows the old value before the edge and the new value after it.
- Reset mid-transaction (in WAIT or on the committing edge): the transaction is abandoned, no write occurs, no resp_valid is produced, and the FSM returns to IDLE.
- req_we/req_addr/req_wdata changing while not in IDLE have no effect.

Decomposition:
- Shared package mem_resp_pkg:
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2.
  - Default widths ADDR_W=9, CNT_W=16.
- One natural sub-module, sat_counter: CNT_W-bit saturating incrementer with synchronous reset. It is instantiated twice, for rd_count and wr_count.
- The memory array and FSM stay in mem_responder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> req_ready=1, resp_valid=0, rd_count=wr_count=0.
- Store then load, WAIT_CYCLES=2: store 0xDEADBEEF to addr 5, then load addr 5 -> resp_valid exactly 3 cycles after each acceptance edge; load resp_rdata=0xDEADBEEF; wr_count=1, rd_count=1; dbg_addr=5 gives 0xDEADBEEF.
- Zero wait states, WAIT_CYCLES=0: load addr 0 accepted at edge T -> resp_valid in the cycle after edge T+1; req_ready low only during RESP.
- Out of range, DEPTH=256: store to addr 300 -> resp_err=1, resp_rdata=0, wr_count unchanged; dbg_addr=300 gives dbg_data=0.
- Reset mid-operation: store 0x1234 to addr 7 (previously 0xAAAA), assert rst during WAIT -> no resp_valid; mem[7] still 0xAAAA; counters 0; FSM in IDLE.
- Saturation, CNT_W=4: 17 successful loads -> rd_count=4'hF and stays there.
